// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID->EX pipeline register slice.
package id_ex_stage_pkg;

    // Bit positions inside the 2-bit operand select sent to ex_forwarding
    localparam int unsigned SEL_FWD_BIT = 1;   // take wb_val (forwarded result)
    localparam int unsigned SEL_ALT_BIT = 0;   // take pc (A) or imm (B)

    localparam logic [4:0]  X0               = 5'd0;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [1:0] sel_t;

    function automatic sel_t make_sel(input logic fwd, input logic alt);
        sel_t s;
        s              = '0;
        s[SEL_FWD_BIT] = fwd;
        s[SEL_ALT_BIT] = alt;
        return s;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX stage bus: decode inputs, WB write-back snoop, and registered EX outputs.
interface id_ex_stage_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic             flush;
    logic             id_valid;
    logic [31:0]      id_pc;
    logic [31:0]      id_imm;
    logic [31:0]      id_rs1_data;
    logic [31:0]      id_rs2_data;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             id_regwen;
    logic             id_a_pc;
    logic             id_b_imm;
    logic [4:0]       wb_rd;
    logic             wb_regwen;
    logic [31:0]      wb_val;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_imm;
    logic [31:0]      ex_rs1;
    logic [31:0]      ex_rs2;
    logic [1:0]       ex_asel;
    logic [1:0]       ex_bsel;
    logic [4:0]       ex_rd;
    logic             ex_regwen;
    logic [CNT_W-1:0] bubble_cnt;

    // Driven by decode / pipeline control
    modport master (
        output stall, flush, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
               id_rs1, id_rs2, id_rd, id_regwen, id_a_pc, id_b_imm,
               wb_rd, wb_regwen, wb_val,
        input  ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_asel, ex_bsel,
               ex_rd, ex_regwen, bubble_cnt
    );

    // The pipeline register itself
    modport slave (
        input  stall, flush, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
               id_rs1, id_rs2, id_rd, id_regwen, id_a_pc, id_b_imm,
               wb_rd, wb_regwen, wb_val,
        output ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_asel, ex_bsel,
               ex_rd, ex_regwen, bubble_cnt
    );

endinterface

// File: rtl/id_ex_stage_fwd_detect.sv
// Hazard comparator for one source register index: EX (newer) and WB (older) hits.
module fwd_detect
    import id_ex_stage_pkg::*;
(
    input  logic [4:0] src,
    input  logic       ex_valid,
    input  logic       ex_regwen,
    input  logic [4:0] ex_rd,
    input  logic       wb_regwen,
    input  logic [4:0] wb_rd,
    output logic       ex_hit,
    output logic       wb_hit
);

    // x0 is never a real producer, so it can never hit
    always_comb begin
        ex_hit = ex_valid & ex_regwen & (ex_rd != X0) & (ex_rd == src);
        wb_hit = wb_regwen & (wb_rd != X0) & (wb_rd == src);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: captures operands, builds forwarding selects,
// patches same-cycle WB writes, inserts bubbles and counts bubble cycles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 32
)(
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    logic             ex_valid_q;
    logic [31:0]      ex_pc_q;
    logic [31:0]      ex_imm_q;
    logic [31:0]      ex_rs1_q;
    logic [31:0]      ex_rs2_q;
    sel_t             ex_asel_q;
    sel_t             ex_bsel_q;
    logic [4:0]       ex_rd_q;
    logic             ex_regwen_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic ex_hit1, wb_hit1, ex_hit2, wb_hit2;
    logic next_is_bubble;

    fwd_detect u_fwd_rs1 (
        .src       (bus.id_rs1),
        .ex_valid  (ex_valid_q),
        .ex_regwen (ex_regwen_q),
        .ex_rd     (ex_rd_q),
        .wb_regwen (bus.wb_regwen),
        .wb_rd     (bus.wb_rd),
        .ex_hit    (ex_hit1),
        .wb_hit    (wb_hit1)
    );

    fwd_detect u_fwd_rs2 (
        .src       (bus.id_rs2),
        .ex_valid  (ex_valid_q),
        .ex_regwen (ex_regwen_q),
        .ex_rd     (ex_rd_q),
        .wb_regwen (bus.wb_regwen),
        .wb_rd     (bus.wb_rd),
        .ex_hit    (ex_hit2),
        .wb_hit    (wb_hit2)
    );

    // A bubble enters EX on flush or when ID has nothing valid
    always_comb begin
        next_is_bubble = bus.flush | ~bus.id_valid;
    end

    // Pipeline register: rst > stall > flush > capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_regwen_q <= 1'b0;
            ex_rd_q     <= X0;
            ex_asel_q   <= '0;
            ex_bsel_q   <= '0;
            ex_pc_q     <= RESET_PC;
            ex_imm_q    <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
        end else if (!bus.stall) begin
            if (bus.flush) begin
                ex_valid_q  <= 1'b0;
                ex_regwen_q <= 1'b0;
                ex_rd_q     <= X0;
                ex_asel_q   <= '0;
                ex_bsel_q   <= '0;
                ex_pc_q     <= '0;
                ex_imm_q    <= '0;
                ex_rs1_q    <= '0;
                ex_rs2_q    <= '0;
            end else begin
                ex_valid_q  <= bus.id_valid;
                ex_regwen_q <= bus.id_regwen & bus.id_valid;
                ex_rd_q     <= bus.id_rd;
                ex_pc_q     <= bus.id_pc;
                ex_imm_q    <= bus.id_imm;
                // Forward bit stays set alongside the alt bit: the branch
                // comparator still needs the forwarded register value.
                ex_asel_q   <= make_sel(ex_hit1 & bus.id_valid, bus.id_a_pc);
                ex_bsel_q   <= make_sel(ex_hit2 & bus.id_valid, bus.id_b_imm);
                ex_rs1_q    <= wb_hit1 ? bus.wb_val : bus.id_rs1_data;
                ex_rs2_q    <= wb_hit2 ? bus.wb_val : bus.id_rs2_data;
            end
        end
    end

    // Saturating count of non-stalled cycles that load a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (!bus.stall && next_is_bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_pc      = ex_pc_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_rs1     = ex_rs1_q;
    assign bus.ex_rs2     = ex_rs2_q;
    assign bus.ex_asel    = ex_asel_q;
    assign bus.ex_bsel    = ex_bsel_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_regwen  = ex_regwen_q;
    assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against a behavioural model of the pipeline register.
module tb_id_ex_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_ex_stage_if #(.CNT_W(32)) bus ();

    id_ex_stage #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model of what EX must hold
    logic        m_valid, m_regwen;
    logic [31:0] m_pc, m_imm, m_rs1, m_rs2, m_cnt;
    logic [1:0]  m_asel, m_bsel;
    logic [4:0]  m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst             = 1'b0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.id_valid    = 1'b0;
        bus.id_pc       = '0;
        bus.id_imm      = '0;
        bus.id_rs1_data = '0;
        bus.id_rs2_data = '0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
        bus.id_regwen   = 1'b0;
        bus.id_a_pc     = 1'b0;
        bus.id_b_imm    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_regwen   = 1'b0;
        bus.wb_val      = '0;
    endtask

    // Next EX contents from the rules: who produced which register most recently
    task automatic model_update();
        bit ex_prod1, ex_prod2, wb_prod1, wb_prod2, bubble;
        if (rst) begin
            m_valid = 0; m_regwen = 0; m_rd = 0; m_asel = 0; m_bsel = 0;
            m_pc = RST_PC; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_cnt = 0;
            return;
        end
        if (bus.stall) return;
        bubble = bus.flush || !bus.id_valid;
        if (bubble && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (bus.flush) begin
            m_valid = 0; m_regwen = 0; m_rd = 0; m_asel = 0; m_bsel = 0;
            m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0;
            return;
        end
        // an EX instruction that really writes a non-zero register it names
        ex_prod1 = bus.id_valid && m_valid && m_regwen && m_rd != 0 && m_rd == bus.id_rs1;
        ex_prod2 = bus.id_valid && m_valid && m_regwen && m_rd != 0 && m_rd == bus.id_rs2;
        wb_prod1 = bus.wb_regwen && bus.wb_rd != 0 && bus.wb_rd == bus.id_rs1;
        wb_prod2 = bus.wb_regwen && bus.wb_rd != 0 && bus.wb_rd == bus.id_rs2;
        m_asel   = 2 * int'(ex_prod1) + int'(bus.id_a_pc);
        m_bsel   = 2 * int'(ex_prod2) + int'(bus.id_b_imm);
        m_rs1    = wb_prod1 ? bus.wb_val : bus.id_rs1_data;
        m_rs2    = wb_prod2 ? bus.wb_val : bus.id_rs2_data;
        m_valid  = bus.id_valid;
        m_regwen = bus.id_valid && bus.id_regwen;
        m_rd     = bus.id_rd;
        m_pc     = bus.id_pc;
        m_imm    = bus.id_imm;
    endtask

    task automatic compare_all();
        chk("ex_valid",   {31'd0, bus.ex_valid},  {31'd0, m_valid});
        chk("ex_pc",      bus.ex_pc,              m_pc);
        chk("ex_imm",     bus.ex_imm,             m_imm);
        chk("ex_rs1",     bus.ex_rs1,             m_rs1);
        chk("ex_rs2",     bus.ex_rs2,             m_rs2);
        chk("ex_asel",    {30'd0, bus.ex_asel},   {30'd0, m_asel});
        chk("ex_bsel",    {30'd0, bus.ex_bsel},   {30'd0, m_bsel});
        chk("ex_rd",      {27'd0, bus.ex_rd},     {27'd0, m_rd});
        chk("ex_regwen",  {31'd0, bus.ex_regwen}, {31'd0, m_regwen});
        chk("bubble_cnt", bus.bubble_cnt,         m_cnt);
    endtask

    // One clock: model sees the same inputs the DUT samples, then compare after the edge
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic regwen, input logic a_pc, input logic b_imm);
        bus.id_valid  = 1'b1;
        bus.id_pc     = pc;
        bus.id_imm    = pc ^ 32'h5A5A_0000;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
        bus.id_regwen = regwen;
        bus.id_a_pc   = a_pc;
        bus.id_b_imm  = b_imm;
    endtask

    logic [31:0] cnt_snap;

    initial begin
        idle();
        m_cnt = 32'hxxxx_xxxx;
        #2;

        // Reset
        rst = 1'b1;
        step();
        chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_pc",    bus.ex_pc, 32'h0000_1000);
        chk("rst_cnt",   bus.bubble_cnt, 32'd0);
        rst = 1'b0;

        // Back-to-back RAW: addi x5,x0,7 ; add x6,x5,x5
        instr(32'h100, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        bus.id_imm = 32'd7;
        step();
        instr(32'h104, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        step();
        chk("raw_asel", {30'd0, bus.ex_asel}, 32'h2);
        chk("raw_bsel", {30'd0, bus.ex_bsel}, 32'h2);

        // WB patch with no EX producer in front
        idle();
        step();
        instr(32'h200, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        bus.wb_rd = 5'd7; bus.wb_regwen = 1'b1; bus.wb_val = 32'hDEAD_BEEF;
        step();
        chk("wbp_rs1",  bus.ex_rs1, 32'hDEAD_BEEF);
        chk("wbp_asel", {30'd0, bus.ex_asel}, 32'h0);

        // x0 destination never forwards
        idle();
        instr(32'h300, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        instr(32'h304, 5'd0, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        chk("x0_asel", {30'd0, bus.ex_asel}, 32'h0);

        // EX and WB both target x3: EX wins via select
        idle();
        instr(32'h400, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        instr(32'h404, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        bus.wb_rd = 5'd3; bus.wb_regwen = 1'b1; bus.wb_val = 32'h1234_5678;
        step();
        chk("both_asel", {30'd0, bus.ex_asel}, 32'h2);

        // auipc/branch: a_pc + b_imm with rs1 produced in EX
        idle();
        instr(32'h500, 5'd1, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        instr(32'h504, 5'd9, 5'd0, 5'd10, 1'b0, 1'b1, 1'b1);
        step();
        chk("br_asel", {30'd0, bus.ex_asel}, 32'h3);
        chk("br_bsel", {30'd0, bus.ex_bsel}, 32'h1);
        chk("br_pc",   bus.ex_pc, 32'h504);

        // Stall for three cycles (with flush also asserted on the last)
        cnt_snap = m_cnt;
        instr(32'h600, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0);
        bus.stall = 1'b1;
        step(); step();
        bus.flush = 1'b1;
        step();
        chk("stall_pc",  bus.ex_pc, 32'h504);
        chk("stall_cnt", bus.bubble_cnt, cnt_snap);

        // Flush alone loads a bubble and counts it
        bus.stall = 1'b0;
        step();
        chk("flush_valid",  {31'd0, bus.ex_valid}, 32'd0);
        chk("flush_regwen", {31'd0, bus.ex_regwen}, 32'd0);
        chk("flush_cnt",    bus.bubble_cnt, cnt_snap + 32'd1);
        bus.flush = 1'b0;

        // Reset mid-stream with a valid instruction in EX
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("mid_rst_pc",    bus.ex_pc, 32'h0000_1000);
        chk("mid_rst_cnt",   bus.bubble_cnt, 32'd0);

        // Randomized traffic; small index range so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 63) == 0);
            bus.stall       = ($urandom_range(0, 7) == 0);
            bus.flush       = ($urandom_range(0, 7) == 0);
            bus.id_valid    = ($urandom_range(0, 3) != 0);
            bus.id_pc       = $urandom;
            bus.id_imm      = $urandom;
            bus.id_rs1_data = $urandom;
            bus.id_rs2_data = $urandom;
            bus.id_rs1      = 5'($urandom_range(0, 3));
            bus.id_rs2      = 5'($urandom_range(0, 3));
            bus.id_rd       = 5'($urandom_range(0, 3));
            bus.id_regwen   = 1'($urandom_range(0, 1));
            bus.id_a_pc     = 1'($urandom_range(0, 1));
            bus.id_b_imm    = 1'($urandom_range(0, 1));
            bus.wb_rd       = 5'($urandom_range(0, 3));
            bus.wb_regwen   = 1'($urandom_range(0, 1));
            bus.wb_val      = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
